// File: rtl/param_priority_arbiter_pkg.sv
// Shared types for the parameterised priority arbiter.
package arb_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

endpackage

// File: rtl/param_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface param_priority_arbiter_if #(parameter int N = 4);
  import arb_pkg::*;

  localparam int IDX_W = $clog2(N);

  arb_mode_e        MODE;
  logic [N-1:0]     REQ;
  logic [N-1:0]     GNT;
  logic             GNT_VALID;
  logic [IDX_W-1:0] GNT_IDX;

  modport master (output MODE, REQ, input GNT, GNT_VALID, GNT_IDX);
  modport slave  (input MODE, REQ, output GNT, GNT_VALID, GNT_IDX);

endinterface

// File: rtl/param_priority_arbiter_pick.sv
// Combinational winner selection: rotate by pointer, pick highest, un-rotate.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  arb_mode_e        mode_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             win_valid_o,
  output logic [IDX_W-1:0] win_idx_o
);

  localparam int             SW = IDX_W + 1;
  localparam logic [SW-1:0]  NN = SW'(N);

  logic [N-1:0]  rot;
  logic [SW-1:0] base, src, hi, sum;

  // rot[k] = req[(k + base) mod N]; top of rot is ptr-1, bottom is ptr itself.
  always_comb begin
    rot  = '0;
    hi   = '0;
    src  = '0;
    base = (mode_i == ARB_RR) ? {1'b0, ptr_i} : '0;
    for (int k = 0; k < N; k++) begin
      src = SW'(k) + base;
      if (src >= NN) src = src - NN;
      rot[k] = req_i[src[IDX_W-1:0]];
    end
    for (int k = 0; k < N; k++) begin
      if (rot[k]) hi = SW'(k);
    end
    sum = hi + base;
    if (sum >= NN) sum = sum - NN;
    win_valid_o = |rot;
    win_idx_o   = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/param_priority_arbiter.sv
// N-way arbiter with fixed/round-robin modes, grant hold and hold-limit re-arbitration.
module param_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  param_priority_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e       state_q, state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             arb_pt;

  arb_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req_i       (bus.REQ),
    .mode_i      (bus.MODE),
    .ptr_i       (rr_ptr_q),
    .win_valid_o (win_vld),
    .win_idx_o   (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;

    arb_pt = (state_q == ARB_IDLE) || !bus.REQ[gnt_idx_q] ||
             ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST));

    if (arb_pt) begin
      hold_cnt_d = '0;
      if (win_vld) begin
        state_d   = ARB_GRANT;
        rr_ptr_d  = win_idx;
        gnt_d     = N'(1) << win_idx;
        gnt_idx_d = win_idx;
        gnt_vld_d = 1'b1;
      end else begin
        state_d   = ARB_IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
        gnt_vld_d = 1'b0;
      end
    end else if (MAX_HOLD != 0) begin
      // Unlimited tenure leaves the counter parked at zero.
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.GNT_IDX   = gnt_idx_q;
  assign bus.GNT_VALID = gnt_vld_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed bench: hold-limited (MAX_HOLD=4) and unlimited (MAX_HOLD=0) arbiters side by side.
module tb_param_priority_arbiter;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] req = '0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  param_priority_arbiter_if #(.N(4)) bus4 ();
  param_priority_arbiter_if #(.N(4)) bus0 ();

  assign bus4.REQ  = req;
  assign bus4.MODE = arb_mode_e'(mode);
  assign bus0.REQ  = req;
  assign bus0.MODE = arb_mode_e'(mode);

  param_priority_arbiter #(.N(4), .MAX_HOLD(4)) u_h4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  param_priority_arbiter #(.N(4), .MAX_HOLD(0)) u_h0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [3:0] g);
    idx_of = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx_of = i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on both instances every cycle.
  always @(negedge clk) begin
    chk("h4_onehot", {31'd0, $onehot0(bus4.GNT)}, 1);
    chk("h4_valid",  {31'd0, bus4.GNT_VALID}, {31'd0, |bus4.GNT});
    chk("h4_idx",    {30'd0, bus4.GNT_IDX}, idx_of(bus4.GNT));
    chk("h0_onehot", {31'd0, $onehot0(bus0.GNT)}, 1);
    chk("h0_valid",  {31'd0, bus0.GNT_VALID}, {31'd0, |bus0.GNT});
    chk("h0_idx",    {30'd0, bus0.GNT_IDX}, idx_of(bus0.GNT));
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_gnt4", {28'd0, bus4.GNT}, 0);
    chk("rst_vld4", {31'd0, bus4.GNT_VALID}, 0);
    chk("rst_gnt0", {28'd0, bus0.GNT}, 0);
    reset_n = 1'b1;

    // Fixed priority, all requesting: index 3 wins and keeps winning
    req = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      step();
      chk("fix_all_h0", {28'd0, bus0.GNT}, 32'h8);
      chk("fix_all_h4", {28'd0, bus4.GNT}, 32'h8);
    end
    req = 4'b0111;
    step();
    chk("fix_drop_h0", {28'd0, bus0.GNT}, 32'h4);
    chk("fix_drop_vld", {31'd0, bus0.GNT_VALID}, 1);

    // Asynchronous reset mid-grant clears outputs immediately
    reset_n = 1'b0;
    #1;
    chk("async_gnt4", {28'd0, bus4.GNT}, 0);
    chk("async_vld4", {31'd0, bus4.GNT_VALID}, 0);
    chk("async_gnt0", {28'd0, bus0.GNT}, 0);
    req = 4'b0101;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst4", {28'd0, bus4.GNT}, 32'h4);
    chk("post_rst0", {28'd0, bus0.GNT}, 32'h4);

    // Round-robin rotation with hold limit 4
    reset_n = 1'b0;
    mode = 1'b1;
    req = 4'b1111;
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 17; c++) begin
      step();
      chk("rr_gnt", {28'd0, bus4.GNT}, 32'h8 >> ((c / 4) % 4));
      chk("rr_idx", {30'd0, bus4.GNT_IDX}, 3 - ((c / 4) % 4));
    end

    // Lone requester re-granted at the limit without a gap
    reset_n = 1'b0;
    req = 4'b0010;
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("lone_gnt", {28'd0, bus4.GNT}, 32'h2);
      chk("lone_vld", {31'd0, bus4.GNT_VALID}, 1);
    end

    // Release hands over at the same edge; search starts from rr_ptr-1
    req = 4'b0100;
    step();
    chk("rr_to2", {28'd0, bus4.GNT}, 32'h4);
    req = 4'b1001;
    step();
    chk("rr_from2", {28'd0, bus4.GNT}, 32'h1);

    // MODE change mid-tenure takes effect only at the next arbitration
    reset_n = 1'b0;
    mode = 1'b0;
    req = 4'b1011;
    #1;
    reset_n = 1'b1;
    step();
    chk("mode_first", {28'd0, bus4.GNT}, 32'h8);
    mode = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mode_hold", {28'd0, bus4.GNT}, 32'h8);
    end
    step();
    chk("mode_rr_next", {28'd0, bus4.GNT}, 32'h2);
    chk("mode_unlim",   {28'd0, bus0.GNT}, 32'h8);
    req = 4'b0000;
    step();
    chk("idle_gnt", {28'd0, bus4.GNT}, 0);
    chk("idle_idx", {30'd0, bus4.GNT_IDX}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
